// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and op classification for the MDU.
package mdu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] MD_NOP   = 4'd0;
  localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MD_MADD  = 4'd5;
  localparam logic [OP_W-1:0] MD_MADDU = 4'd6;
  localparam logic [OP_W-1:0] MD_MSUB  = 4'd7;
  localparam logic [OP_W-1:0] MD_MSUBU = 4'd8;
  localparam logic [OP_W-1:0] MD_MTHI  = 4'd9;
  localparam logic [OP_W-1:0] MD_MTLO  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DFIX = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic is_mul;
    logic is_div;
    logic is_signed;
    logic is_acc;
    logic is_sub;
    logic is_mthi;
    logic is_mtlo;
  } op_class_t;

  // Decode an op code into its class flags; unknown codes decode to all-zero (NOP).
  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    op_class_t c;
    c = '0;
    case (op)
      MD_MULT:  begin c.is_mul = 1'b1; c.is_signed = 1'b1; end
      MD_MULTU: begin c.is_mul = 1'b1; end
      MD_DIV:   begin c.is_div = 1'b1; c.is_signed = 1'b1; end
      MD_DIVU:  begin c.is_div = 1'b1; end
      MD_MADD:  begin c.is_mul = 1'b1; c.is_signed = 1'b1; c.is_acc = 1'b1; end
      MD_MADDU: begin c.is_mul = 1'b1; c.is_acc = 1'b1; end
      MD_MSUB:  begin c.is_mul = 1'b1; c.is_signed = 1'b1; c.is_acc = 1'b1; c.is_sub = 1'b1; end
      MD_MSUBU: begin c.is_mul = 1'b1; c.is_acc = 1'b1; c.is_sub = 1'b1; end
      MD_MTHI:  begin c.is_mthi = 1'b1; end
      MD_MTLO:  begin c.is_mtlo = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             done_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // Trial subtraction; when it fits the true difference is below the divisor, so W bits suffice.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[WIDTH-1:0] - dvs_q;
    done_c  = active_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Remainder/quotient shift register and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (kill) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      quot_q   <= dividend;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q  <= fits ? diff : shifted[WIDTH-1:0];
      quot_q <= {quot_q[WIDTH-2:0], fits};
      if (done_c) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu_iter_unit.sv
// Multiply/divide unit owning HI/LO: delayed multiply/MAC path, iterative divider, flush support.
module mdu_iter_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 4;

  mdu_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    prod_q, prod_d;
  logic             acc_q, acc_d, sub_q, sub_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  op_class_t        cls;
  logic             accept;
  logic [DW-1:0]    ext_a, ext_b, prod_c, hilo, mul_res;
  logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
  logic [WIDTH-1:0] div_quot, div_rem;
  logic             div_start_c, div_kill_c, div_done_c;

  // Operand conditioning: extension for the multiplier, magnitudes for the divider.
  always_comb begin
    cls     = classify(op);
    accept  = start && !flush && (state_q == IDLE);
    ext_a   = cls.is_signed ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
    ext_b   = cls.is_signed ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
    prod_c  = ext_a * ext_b;
    mag_a   = (cls.is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    mag_b   = (cls.is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    hilo    = {hi_q, lo_q};
    mul_res = !acc_q ? prod_q : (sub_q ? hilo - prod_q : hilo + prod_q);
    q_fix   = qneg_q ? -div_quot : div_quot;
    r_fix   = rneg_q ? -div_rem : div_rem;
  end

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start_c),
    .kill     (div_kill_c),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quot     (div_quot),
    .rem      (div_rem),
    .done_c   (div_done_c)
  );

  // Next-state and datapath control; flush overrides everything while an op is in flight.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    sub_d       = sub_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    div_start_c = 1'b0;
    div_kill_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cls.is_mthi) begin
            hi_d = rs_val;
          end else if (cls.is_mtlo) begin
            lo_d = rs_val;
          end else if (cls.is_mul) begin
            state_d = MUL;
            busy_d  = 1'b1;
            prod_d  = prod_c;
            acc_d   = cls.is_acc;
            sub_d   = cls.is_sub;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end else if (cls.is_div) begin
            busy_d = 1'b1;
            qneg_d = cls.is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            rneg_d = cls.is_signed && rs_val[WIDTH-1];
            if (rt_val == '0) begin
              // Divide by zero skips the iterations; the dividend is parked in prod_q for HI.
              state_d = DFIX;
              dz_d    = 1'b1;
              prod_d  = {{WIDTH{1'b0}}, rs_val};
            end else begin
              state_d     = DIV;
              dz_d        = 1'b0;
              div_start_c = 1'b1;
            end
          end
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          {hi_d, lo_d} = mul_res;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DIV: begin
        if (div_done_c) state_d = DFIX;
      end
      DFIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (dz_q) begin
          hi_d = prod_q[WIDTH-1:0];
          lo_d = '1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (flush && (state_q != IDLE)) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      cnt_d      = '0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_kill_c = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Randomised and directed bench for mdu_iter_unit against an arithmetic reference model.
module tb_mdu_iter_unit;
  import mdu_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned MUL_LAT = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  rt_val;
  logic          flush;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] m_hi, m_lo;

  mdu_iter_unit #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result of {hi,lo} after op completes, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint     sp;
    logic [63:0] up;
    int         sa, sb;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'd0, a} * {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      MD_MULT:  return 64'(sp);
      MD_MULTU: return up;
      MD_MADD:  return acc + 64'(sp);
      MD_MADDU: return acc + up;
      MD_MSUB:  return acc - 64'(sp);
      MD_MSUBU: return acc - up;
      MD_MTHI:  return {a, acc[31:0]};
      MD_MTLO:  return {acc[63:32], a};
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default:  return acc;
    endcase
  endfunction

  function automatic int busy_len(input logic [3:0] o, input logic [31:0] b);
    case (o)
      MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return MUL_LAT;
      MD_DIV, MD_DIVU: return (b == 32'd0) ? 1 : W + 1;
      default: return 0;
    endcase
  endfunction

  // Issue one op; optionally flush at busy cycle flush_at or poke a stray start at poke_at.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at);
    logic [63:0] exp_hl;
    int          exp_busy;
    int          nb;
    logic        early;
    exp_busy = busy_len(o, b);
    exp_hl   = ref_result(o, a, b, {m_hi, m_lo});
    if (flush_at > 0 && flush_at <= exp_busy) begin
      exp_hl   = {m_hi, m_lo};
      exp_busy = flush_at;
    end
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start = 1'b0;
    nb    = 0;
    early = 1'b0;
    while (busy && nb < 200) begin
      nb++;
      if ({hi, lo} !== {m_hi, m_lo}) early = 1'b1;
      if (nb == flush_at) flush = 1'b1;
      if (nb == poke_at) begin
        start  = 1'b1;
        op     = MD_MTLO;
        rs_val = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
    end
    check($sformatf("busy_cycles op%0d", o), 64'(nb), 64'(exp_busy));
    check($sformatf("hilo op%0d a=%h b=%h", o, a, b), {hi, lo}, exp_hl);
    check($sformatf("no_early_write op%0d", o), 64'(early), 64'd0);
    {m_hi, m_lo} = exp_hl;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3, 4:    return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int          len, fa;
    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = MD_NOP;
    rs_val = '0;
    rt_val = '0;
    m_hi   = '0;
    m_lo   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("t1_mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("t1_multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("t2_div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIVU, 32'd100, 32'd7, 0, 0);
    check("t2_divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("t2_div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(MD_DIVU, 32'h1234, 32'd0, 0, 0);
    check("t3_dz_const", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op(MD_MTHI, 32'h1, 32'd0, 0, 0);
    run_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 0);
    run_op(MD_MADDU, 32'd1, 32'd1, 0, 0);
    check("t4_maddu_const", {hi, lo}, {32'h2, 32'h0});
    run_op(MD_MSUB, 32'd1, 32'd1, 0, 0);
    check("t4_msub_const", {hi, lo}, {32'h1, 32'hFFFF_FFFF});
    run_op(MD_DIV, 32'h1234_5678, 32'd9, 10, 0);
    run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 0, 2);
    run_op(MD_DIVU, 32'hFFFF_FFFF, 32'd3, 0, 5);
    run_op(4'd12, 32'h5555_5555, 32'd1, 0, 0);

    // start together with flush is ignored
    start  = 1'b1;
    flush  = 1'b1;
    op     = MD_MTHI;
    rs_val = 32'hCAFE_F00D;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    check("start_flush_hilo", {hi, lo}, {m_hi, m_lo});

    // Asynchronous reset mid-multiply
    run_op(MD_MTHI, 32'hA5A5_0001, 32'd0, 0, 0);
    start  = 1'b1;
    op     = MD_MULT;
    rs_val = 32'd1234;
    rt_val = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi  = '0;
    m_lo  = '0;
    repeat (MUL_LAT + 2) @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_hilo", {hi, lo}, 64'd0);

    // Randomised ops, with occasional flushes
    for (int i = 0; i < 80; i++) begin
      ro  = 4'($urandom_range(0, 11));
      ra  = rand_opnd();
      rb  = rand_opnd();
      len = busy_len(ro, rb);
      fa  = 0;
      if (len > 0 && $urandom_range(0, 7) == 0) fa = $urandom_range(1, len);
      run_op(ro, ra, rb, fa, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
